// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load extraction, writeback select and retire counter.
// Register-file write port is driven purely from the registered WB fields.
module mem_wb_stage #(
    parameter int XLEN      = 32,
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [4:0]           in_rd,
    input  logic                 in_reg_write,
    input  logic [1:0]           in_wb_sel,
    input  logic [XLEN-1:0]      in_alu_result,
    input  logic [XLEN-1:0]      in_pc_plus4,
    input  logic [XLEN-1:0]      in_load_word,
    input  logic [2:0]           in_funct3,
    output logic [4:0]           rd,
    output logic [XLEN-1:0]      rd_data,
    output logic                 we,
    output logic                 wb_valid,
    output logic [INSTRET_W-1:0] instret
);

    typedef struct packed {
        logic            valid;
        logic [4:0]      rd;
        logic            reg_write;
        logic [1:0]      wb_sel;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] word;
        logic [2:0]      funct3;
    } wb_t;

    wb_t wb_q;
    wb_t wb_in;

    always_comb begin
        wb_in.valid     = in_valid;
        wb_in.rd        = in_rd;
        wb_in.reg_write = in_reg_write;
        wb_in.wb_sel    = in_wb_sel;
        wb_in.alu       = in_alu_result;
        wb_in.pc4       = in_pc_plus4;
        wb_in.word      = in_load_word;
        wb_in.funct3    = in_funct3;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_q <= '0;
        end else if (flush) begin
            wb_q <= '0;
        end else if (!stall) begin
            wb_q <= wb_in;
        end
    end

    // The WB instruction retires on the edge it leaves the stage (advance or flush).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instret <= '0;
        end else if (wb_q.valid && (!stall || flush)) begin
            instret <= instret + INSTRET_W'(1);
        end
    end

    logic [1:0]      off;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] load_val;
    logic [XLEN-1:0] sel_val;

    assign off = wb_q.alu[1:0];

    always_comb begin
        ld_byte = 8'h00;
        case (off)
            2'd0: ld_byte = wb_q.word[7:0];
            2'd1: ld_byte = wb_q.word[15:8];
            2'd2: ld_byte = wb_q.word[23:16];
            2'd3: ld_byte = wb_q.word[31:24];
            default: ld_byte = 8'h00;
        endcase
        // off[0] ignored: misaligned halfwords trap before reaching here.
        ld_half = off[1] ? wb_q.word[31:16] : wb_q.word[15:0];
        case (wb_q.funct3)
            3'b000:  load_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100:  load_val = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001:  load_val = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b101:  load_val = {{(XLEN-16){1'b0}}, ld_half};
            default: load_val = wb_q.word;
        endcase
    end

    always_comb begin
        case (wb_q.wb_sel)
            2'b01:   sel_val = load_val;
            2'b10:   sel_val = wb_q.pc4;
            default: sel_val = wb_q.alu;
        endcase
    end

    assign rd       = wb_q.rd;
    assign wb_valid = wb_q.valid;
    assign we       = wb_q.valid & wb_q.reg_write & (wb_q.rd != 5'd0);
    assign rd_data  = wb_q.valid ? sel_val : '0;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed table-driven bench for mem_wb_stage plus stall/flush/reset sequences.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush, in_valid, in_reg_write;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [31:0] in_alu_result, in_pc_plus4, in_load_word;
    logic [2:0]  in_funct3;
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic        we, wb_valid;
    logic [63:0] instret;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_cnt;
    logic        model_valid;

    mem_wb_stage #(.XLEN(32), .INSTRET_W(64)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_rd(in_rd), .in_reg_write(in_reg_write),
        .in_wb_sel(in_wb_sel), .in_alu_result(in_alu_result),
        .in_pc_plus4(in_pc_plus4), .in_load_word(in_load_word),
        .in_funct3(in_funct3), .rd(rd), .rd_data(rd_data), .we(we),
        .wb_valid(wb_valid), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  sel;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] word;
        logic [2:0]  f3;
        logic        ewe;
        logic [4:0]  erd;
        logic [31:0] edata;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(logic v, logic [4:0] r, logic rw, logic [1:0] sel,
                                logic [31:0] alu, logic [31:0] pc4, logic [2:0] f3,
                                logic ewe, logic [31:0] edata);
        vec_t t;
        t.v = v; t.rd = r; t.rw = rw; t.sel = sel; t.alu = alu; t.pc4 = pc4;
        t.word = 32'h80F17F82; t.f3 = f3; t.ewe = ewe; t.erd = r; t.edata = edata;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        in_valid      = t.v;
        in_rd         = t.rd;
        in_reg_write  = t.rw;
        in_wb_sel     = t.sel;
        in_alu_result = t.alu;
        in_pc_plus4   = t.pc4;
        in_load_word  = t.word;
        in_funct3     = t.f3;
    endtask

    // Edge helper: advances the retire model and lands 1 time unit after posedge.
    task automatic tick(input logic next_valid);
        @(posedge clk);
        if (model_valid && (!stall || flush)) exp_cnt = exp_cnt + 64'd1;
        if (flush) model_valid = 1'b0;
        else if (!stall) model_valid = next_valid;
        #1;
    endtask

    initial begin
        vec_t t;
        tbl[0]  = mk(1, 5, 1, 2'b00, 32'hA5A5A5A5, 32'h0,   3'b000, 1, 32'hA5A5A5A5);
        tbl[1]  = mk(1, 6, 1, 2'b01, 32'h00001000, 32'h0,   3'b000, 1, 32'hFFFFFF82);
        tbl[2]  = mk(1, 6, 1, 2'b01, 32'h00001000, 32'h0,   3'b100, 1, 32'h00000082);
        tbl[3]  = mk(1, 6, 1, 2'b01, 32'h00001001, 32'h0,   3'b000, 1, 32'h0000007F);
        tbl[4]  = mk(1, 6, 1, 2'b01, 32'h00001002, 32'h0,   3'b001, 1, 32'hFFFF80F1);
        tbl[5]  = mk(1, 6, 1, 2'b01, 32'h00001002, 32'h0,   3'b101, 1, 32'h000080F1);
        tbl[6]  = mk(1, 6, 1, 2'b01, 32'h00001003, 32'h0,   3'b010, 1, 32'h80F17F82);
        tbl[7]  = mk(1, 0, 1, 2'b00, 32'hFFFFFFFF, 32'h0,   3'b000, 0, 32'hFFFFFFFF);
        tbl[8]  = mk(1, 1, 1, 2'b10, 32'h0000DEAD, 32'h104, 3'b000, 1, 32'h00000104);
        tbl[9]  = mk(1, 7, 1, 2'b11, 32'h12345678, 32'h200, 3'b000, 1, 32'h12345678);
        tbl[10] = mk(1, 9, 0, 2'b00, 32'h0BADF00D, 32'h0,   3'b000, 0, 32'h0BADF00D);
        tbl[11] = mk(1, 8, 1, 2'b01, 32'h00001003, 32'h0,   3'b000, 1, 32'hFFFFFF80);
        tbl[12] = mk(1, 8, 1, 2'b01, 32'h00001003, 32'h0,   3'b001, 1, 32'hFFFF80F1);
        tbl[13] = mk(1, 8, 1, 2'b01, 32'h00001000, 32'h0,   3'b101, 1, 32'h00007F82);
        tbl[14] = mk(1, 8, 1, 2'b01, 32'h00001001, 32'h0,   3'b011, 1, 32'h80F17F82);
        tbl[15] = mk(1, 8, 1, 2'b01, 32'h00001002, 32'h0,   3'b100, 1, 32'h000000F1);
        tbl[16] = mk(0, 4, 1, 2'b00, 32'h11111111, 32'h0,   3'b000, 0, 32'h00000000);

        exp_cnt = 0; model_valid = 0;
        reset = 1; stall = 0; flush = 0;
        t = mk(0, 0, 0, 2'b00, 32'h0, 32'h0, 3'b000, 0, 32'h0);
        drive(t);
        #3;
        chk("reset_we", {63'd0, we}, 64'd0);
        chk("reset_instret", instret, 64'd0);
        @(negedge clk);
        reset = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0);
            chk("idle_we", {63'd0, we}, 64'd0);
            chk("idle_data", {32'd0, rd_data}, 64'd0);
            chk("idle_valid", {63'd0, wb_valid}, 64'd0);
            chk("idle_instret", instret, 64'd0);
        end

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i]);
            tick(tbl[i].v);
            chk($sformatf("vec%0d_we", i), {63'd0, we}, {63'd0, tbl[i].ewe});
            chk($sformatf("vec%0d_rd", i), {59'd0, rd}, {59'd0, tbl[i].erd});
            chk($sformatf("vec%0d_data", i), {32'd0, rd_data}, {32'd0, tbl[i].edata});
            chk($sformatf("vec%0d_instret", i), instret, exp_cnt);
        end

        // Stall holds a valid instruction for 3 extra cycles; counted once.
        t = mk(1, 3, 1, 2'b00, 32'h00000055, 32'h0, 3'b000, 1, 32'h55);
        drive(t);
        tick(1'b1);
        chk("stall_load_we", {63'd0, we}, 64'd1);
        t = mk(1, 12, 1, 2'b10, 32'hCAFEBABE, 32'h777, 3'b000, 1, 32'h0);
        drive(t);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1);
            chk("stall_we", {63'd0, we}, 64'd1);
            chk("stall_rd", {59'd0, rd}, 64'd3);
            chk("stall_data", {32'd0, rd_data}, 64'h55);
            chk("stall_instret", instret, exp_cnt);
        end
        stall = 0;
        in_valid = 0;
        tick(1'b0);
        chk("stall_release_instret", instret, exp_cnt);
        chk("stall_release_valid", {63'd0, wb_valid}, 64'd0);

        // Flush together with stall: bubble in, held instruction counted.
        t = mk(1, 10, 1, 2'b00, 32'h0000AAAA, 32'h0, 3'b000, 1, 32'hAAAA);
        drive(t);
        tick(1'b1);
        chk("flush_pre_we", {63'd0, we}, 64'd1);
        stall = 1; flush = 1;
        tick(1'b1);
        chk("flush_valid", {63'd0, wb_valid}, 64'd0);
        chk("flush_we", {63'd0, we}, 64'd0);
        chk("flush_data", {32'd0, rd_data}, 64'd0);
        chk("flush_rd", {59'd0, rd}, 64'd0);
        chk("flush_instret", instret, exp_cnt);
        stall = 0; flush = 0;

        // Asynchronous reset mid-cycle with a valid WB instruction.
        drive(t);
        tick(1'b1);
        chk("areset_pre_valid", {63'd0, wb_valid}, 64'd1);
        #2;
        reset = 1;
        #1;
        chk("areset_we", {63'd0, we}, 64'd0);
        chk("areset_valid", {63'd0, wb_valid}, 64'd0);
        chk("areset_data", {32'd0, rd_data}, 64'd0);
        chk("areset_instret", instret, 64'd0);
        in_valid = 0;
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;
        chk("post_reset_instret", instret, 64'd0);
        chk("post_reset_valid", {63'd0, wb_valid}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus writeback logic for the RV32I pipeline.
- Captures the instruction leaving the memory stage.
- Extracts and sign- or zero-extends load data, then selects the writeback value.
- Drives the register file write port (rd, rd_data, we) directly, and keeps a 64-bit retired-instruction counter.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.
- INSTRET_W, 64, width of the retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hold the WB register contents.
- flush  input  1  load a bubble into the WB register. Overrides stall.
- in_valid  input  1  MEM-stage instruction is valid.
- in_rd  input  5  destination register index.
- in_reg_write  input  1  instruction writes rd.
- in_wb_sel  input  2  writeback source: 00 ALU, 01 load, 10 PC+4, 11 ALU.
- in_alu_result  input  XLEN  ALU result. This is also the load address; bits [1:0] are the byte offset.
- in_pc_plus4  input  XLEN  PC+4, used for JAL/JALR.
- in_load_word  input  XLEN  raw aligned 32-bit word returned by data memory.
- in_funct3  input  3  load type.
- rd  output  5  register file write index.
- rd_data  output  XLEN  register file write data.
- we  output  1  register file write enable.
- wb_valid  output  1  WB stage holds a valid instruction.
- instret  output  INSTRET_W  count of retired instructions.

Behaviour:
- Reset:
  - Asynchronous: all WB fields, wb_valid and instret clear immediately.
  - During and after reset: rd=0, rd_data=0, we=0, wb_valid=0, instret=0.
- Register update, on each rising clk edge when not in reset, in priority order:
  - flush=1: wb_valid<=0 and all captured fields <=0. This happens regardless of stall.
  - else stall=1: every field holds.
  - else: capture all in_* fields, with wb_valid<=in_valid.
- Output timing:
  - rd, rd_data and we are combinational from the registered fields only. There is no path from in_* to the outputs.
  - Latency is one cycle from MEM inputs to the register file write port.
- Write enable:
  - we = wb_valid & reg_write & (rd != 0).
  - An x0 destination never asserts we.
  - rd is driven with the registered index even when we=0.
- rd_data when wb_sel = 00 or 11: the registered ALU result.
- rd_data when wb_sel = 10: the registered PC+4.
- rd_data when wb_sel = 01 (load); off is bits [1:0] of the registered ALU result:
  - 000 LB: byte at bits [8*off+7 : 8*off], sign-extended.
  - 100 LBU: the same byte, zero-extended.
  - 001 LH: halfword at bits [16*off[1]+15 : 16*off[1]], sign-extended. off[0] is ignored; misalignment traps upstream.
  - 101 LHU: the same halfword, zero-extended.
  - 010 LW, and undefined codes 011/110/111: the raw load word, with off ignored.
- rd_data is 0 whenever wb_valid=0, so bubbles drive clean zeros.
- Stall behaviour:
  - The held instruction keeps we asserted every stalled cycle.
  - Repeated identical register file writes are idempotent and legal.
- Retire counter:
  - Increments by 1 on a posedge when wb_valid=1 and (stall=0 or flush=1), i.e. when the WB instruction leaves the stage.
  - A stalled instruction is counted exactly once.
  - Bubbles are never counted.
  - Wraps from all-ones to 0 with no flag.
- Reset mid-stream: a pending WB instruction is discarded. It is not written and not counted.

Test Plan:
- Reset then release, no valid inputs for 5 cycles -> we=0, rd_data=0, wb_valid=0, instret=0 throughout.
- ALU write: in_valid=1, rd=5, wb_sel=00, alu=0xA5A5A5A5 -> next cycle we=1, rd=5, rd_data=0xA5A5A5A5; instret=1 after the following edge.
- Loads with word=0x80F17F82, byte-offset path under test:
  - LB off=0 -> 0xFFFFFF82.
  - LBU off=0 -> 0x00000082.
  - LB off=1 -> 0x0000007F.
  - LH off=2 -> 0xFFFF80F1.
  - LHU off=2 -> 0x000080F1.
  - LW off=3 -> 0x80F17F82.
- x0 and JAL:
  - rd=0, reg_write=1, alu=0xFFFFFFFF -> we=0.
  - Then JAL rd=1, pc_plus4=0x00000104 -> we=1, rd_data=0x00000104.
- Stall/flush:
  - Valid instruction held by stall for 3 cycles -> outputs constant and we=1 for 4 cycles; instret increments once.
  - flush asserted together with stall -> wb_valid=0 next cycle, and the held instruction is counted.
- Asynchronous reset asserted mid-cycle with wb_valid=1 -> we and wb_valid drop before the next edge; instret=0.
